// File: rtl/daq_event_builder.sv
// daq_event_builder: coincidence-triggered peak/area collector with timeout, sequence numbering and FWFT event FIFO
module daq_event_builder #(
    parameter int N_CH        = 2,
    parameter int N_T         = 32,
    parameter int N_P         = 12,
    parameter int N_A         = 20,
    parameter int TIMEOUT_CYC = 1024,
    parameter int DEPTH       = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_T-1:0]            time_ms,
    input  logic [N_CH*N_P-1:0]       a_peak,
    input  logic [N_CH*N_A-1:0]       a_area,
    input  logic [N_CH-1:0]           peak_ready,
    input  logic [N_CH-1:0]           area_ready,
    input  logic                      coincidence_flag,
    input  logic [N_CH-1:0]           ch_mask,
    input  logic                      ev_ready,
    output logic                      ev_valid,
    output logic [N_T-1:0]            ev_time,
    output logic [N_CH*N_P-1:0]       ev_peak,
    output logic [N_CH*N_A-1:0]       ev_area,
    output logic [N_CH-1:0]           ev_flags,
    output logic                      ev_timeout,
    output logic [31:0]               ev_number,
    output logic                      busy,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic [15:0]               dropped_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT_CYC);
    localparam int RW = N_T + N_CH * (N_P + N_A + 1) + 33;
    localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, COMMIT} state_t;

    state_t                r_state;
    logic                  r_coin_d, r_to;
    logic [N_CH-1:0]       r_pr_d, r_ar_d, r_mask, r_pflag, r_aflag;
    logic [N_T-1:0]        r_time;
    logic [N_CH*N_P-1:0]   r_peak;
    logic [N_CH*N_A-1:0]   r_area;
    logic [CW-1:0]         r_tcnt;
    logic [31:0]           r_seq;
    logic [15:0]           r_drop;
    logic [RW-1:0]         r_mem [DEPTH];
    logic [AW:0]           r_wr, r_rd;

    logic                  w_coin_rise, w_start, w_collect, w_complete, w_empty, w_pop, w_push;
    logic [N_CH-1:0]       w_p_rise, w_a_rise, w_take_p, w_take_a;
    logic [AW:0]           w_level;
    logic [AW-1:0]         w_head;
    logic [RW-1:0]         w_rec;

    assign w_coin_rise = coincidence_flag & ~r_coin_d;
    assign w_p_rise    = peak_ready & ~r_pr_d;
    assign w_a_rise    = area_ready & ~r_ar_d;
    assign w_start     = (r_state == IDLE) & w_coin_rise;
    assign w_collect   = r_state == COLLECT;
    // Only the first rise per channel is taken; the start cycle accepts rises against freshly cleared flags
    assign w_take_p    = w_p_rise & (w_start ? {N_CH{1'b1}} : w_collect ? ~r_pflag : '0);
    assign w_take_a    = w_a_rise & (w_start ? {N_CH{1'b1}} : w_collect ? ~r_aflag : '0);
    assign w_complete  = &((r_pflag & r_aflag) | ~r_mask);

    assign w_level     = r_wr - r_rd;
    assign w_empty     = w_level == '0;
    assign w_pop       = ~w_empty & ev_ready;
    assign w_push      = (r_state == COMMIT) & (~w_level[AW] | w_pop);
    // When empty, point at the last popped slot so outputs hold their previous value
    assign w_head      = r_rd[AW-1:0] - AW'(w_empty);
    assign w_rec       = {r_time, r_peak, r_area, r_pflag & r_aflag & r_mask, r_to, r_seq};

    assign {ev_time, ev_peak, ev_area, ev_flags, ev_timeout, ev_number} = r_mem[w_head];
    assign ev_valid      = ~w_empty;
    assign busy          = r_state != IDLE;
    assign fifo_level    = w_level;
    assign dropped_count = r_drop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_coin_d <= 1'b0;
            r_pr_d   <= '0;
            r_ar_d   <= '0;
            r_mask   <= '0;
            r_pflag  <= '0;
            r_aflag  <= '0;
            r_time   <= '0;
            r_peak   <= '0;
            r_area   <= '0;
            r_tcnt   <= '0;
            r_to     <= 1'b0;
            r_seq    <= '0;
            r_drop   <= '0;
        end else begin
            r_coin_d <= coincidence_flag;
            r_pr_d   <= peak_ready;
            r_ar_d   <= area_ready;
            r_pflag  <= w_start ? w_p_rise : r_pflag | w_take_p;
            r_aflag  <= w_start ? w_a_rise : r_aflag | w_take_a;
            for (int c = 0; c < N_CH; c++) begin
                if (w_take_p[c]) r_peak[c*N_P +: N_P] <= a_peak[c*N_P +: N_P];
                else if (w_start) r_peak[c*N_P +: N_P] <= '0;
                if (w_take_a[c]) r_area[c*N_A +: N_A] <= a_area[c*N_A +: N_A];
                else if (w_start) r_area[c*N_A +: N_A] <= '0;
            end
            case (r_state)
                IDLE: if (w_coin_rise) begin
                    r_state <= COLLECT;
                    r_time  <= time_ms;
                    r_mask  <= ch_mask;
                    r_tcnt  <= '0;
                end
                COLLECT: if (w_complete || r_tcnt == TERM) begin
                    r_state <= COMMIT;
                    r_to    <= ~w_complete;
                end else begin
                    r_tcnt  <= r_tcnt + 1'b1;
                end
                COMMIT: begin
                    r_state <= IDLE;
                    r_seq   <= r_seq + 32'd1;
                    if (!w_push && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr <= '0;
            r_rd <= '0;
            for (int j = 0; j < DEPTH; j++) r_mem[j] <= '0;
        end else begin
            if (w_push) r_mem[r_wr[AW-1:0]] <= w_rec;
            r_wr <= r_wr + (AW+1)'(w_push);
            r_rd <= r_rd + (AW+1)'(w_pop);
        end
    end
endmodule
